// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: steps a phase increment from f_start toward f_stop,
// holding each value for a programmable dwell, with optional looping and abort.
module sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               loop,
    input  logic [WIDTH-1:0]   f_start,
    input  logic [WIDTH-1:0]   f_stop,
    input  logic [WIDTH-1:0]   f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   incr,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   incr_q;
    logic               en_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   start_q;
    logic [WIDTH-1:0]   stop_q;
    logic [WIDTH-1:0]   step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               loop_q;
    logic               up_q;
    logic [DWELL_W-1:0] cnt_q;

    logic [WIDTH:0]     sum_d;
    logic [WIDTH:0]     diff_d;
    logic [WIDTH-1:0]   next_incr_d;
    logic [DWELL_W-1:0] dwell_last_d;
    logic               expire_d;

    // One extra bit on the add/subtract so clamping happens before any wrap.
    always_comb begin
        sum_d        = {1'b0, incr_q} + {1'b0, step_q};
        diff_d       = {1'b0, incr_q} - {1'b0, step_q};
        next_incr_d  = incr_q;
        if (up_q) begin
            next_incr_d = (sum_d >= {1'b0, stop_q}) ? stop_q : sum_d[WIDTH-1:0];
        end else begin
            next_incr_d = (diff_d[WIDTH] || (diff_d[WIDTH-1:0] <= stop_q)) ?
                          stop_q : diff_d[WIDTH-1:0];
        end
        dwell_last_d = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
        expire_d     = (cnt_q == dwell_last_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            incr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
            up_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q <= ST_SWEEP;
                        start_q <= f_start;
                        stop_q  <= f_stop;
                        step_q  <= f_step;
                        dwell_q <= dwell;
                        loop_q  <= loop;
                        up_q    <= (f_stop >= f_start);
                        cnt_q   <= '0;
                        incr_q  <= f_start;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        incr_q  <= '0;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (expire_d) begin
                        cnt_q <= '0;
                        if (incr_q != stop_q) begin
                            incr_q <= next_incr_d;
                        end else if (loop_q) begin
                            incr_q <= start_q;
                        end else begin
                            state_q <= ST_DONE;
                            incr_q  <= '0;
                            en_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + DWELL_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    incr_q  <= '0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign incr = incr_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, width of the phase-increment values and the incr output.
REQ-002 Parameter DWELL_W, default 16, width of the dwell (cycles-per-step) field.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate a sweep immediately; no done pulse.
REQ-007 loop  input  1  1 = restart at f_start after each completed sweep; sampled at start.
REQ-008 f_start  input  WIDTH  first increment of the sweep; sampled at start.
REQ-009 f_stop  input  WIDTH  final increment of the sweep; sampled at start.
REQ-010 f_step  input  WIDTH  magnitude of the change between successive increments; sampled at start.
REQ-011 dwell  input  DWELL_W  cycles each increment is held; sampled at start.
REQ-012 incr  output  WIDTH  phase increment driven to the phase-accumulator counter.
REQ-013 en  output  1  counter enable; 1 exactly while a sweep is active.
REQ-014 busy  output  1  1 while state is SWEEP.
REQ-015 done  output  1  single-cycle pulse on normal (non-abort, non-loop) completion.

Function
REQ-016 The FSM SHALL have states IDLE, SWEEP and DONE; all outputs are registered.
REQ-017 In IDLE: incr=0, en=0, busy=0, done=0.
REQ-018 In IDLE, start=1 and abort=0 at edge N SHALL latch f_start, f_stop, f_step, dwell and loop, and enter SWEEP at N+1 with incr=f_start, en=1, busy=1.
REQ-019 Sweep direction SHALL be up if f_stop >= f_start and down otherwise, fixed for the whole sweep.
REQ-020 Each increment value SHALL be presented for exactly max(dwell,1) consecutive cycles; a dwell of 0 is treated as 1.
REQ-021 At dwell expiry with incr != f_stop: up = min(incr+f_step, f_stop); down = max(incr-f_step, f_stop); the comparison SHALL be computed in WIDTH+1 bits so the value never wraps or overshoots.
REQ-022 At dwell expiry with incr == f_stop and latched loop=1: incr SHALL return to f_start on the next cycle, and en SHALL remain 1 without a gap.
REQ-023 At dwell expiry with incr == f_stop and latched loop=0: the FSM SHALL enter DONE, with done=1, en=0 and incr=0 for that one cycle, then return to IDLE.
REQ-024 If f_start == f_stop, a sweep SHALL hold f_start for one dwell period and then complete per REQ-022/REQ-023.
REQ-025 If f_step == 0 and f_start != f_stop, incr SHALL stay at f_start indefinitely; only abort or rst ends the sweep.
REQ-026 abort=1 in SWEEP SHALL force IDLE on the next edge (incr=0, en=0, busy=0) with no done pulse.
REQ-027 start while in SWEEP or DONE SHALL be ignored; input changes during a sweep SHALL have no effect.
REQ-028 start and abort both 1 in IDLE: abort wins and the FSM stays in IDLE.
REQ-029 In DONE, abort SHALL have no effect, and done SHALL still pulse.

Reset
REQ-030 rst=1 SHALL, on the next edge, force IDLE, incr=0, en=0, busy=0, done=0 and clear the dwell counter and latched config, from any state including mid-sweep; rst overrides start and abort.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- f_start=10, f_stop=40, f_step=10, dwell=3, loop=0 -> incr 10,20,30,40 each for 3 cycles; en=1 for 12 cycles; done one cycle later; then IDLE.
- f_start=200, f_stop=250, f_step=30, dwell=1 -> incr 200,230,250 (clamped, no wrap at 255); done after the third value.
- f_start=50, f_stop=20, f_step=20, dwell=2 -> down sweep 50,30,20; done follows.
- loop=1, f_start=5, f_stop=7, f_step=1, dwell=0 -> incr 5,6,7,5,6,7... with en continuously 1; abort -> IDLE next cycle, no done.
- rst asserted mid-sweep while start=1 -> next cycle incr=0, en=0, busy=0; sweep does not restart until start after rst deasserts.
- start and abort both 1 in IDLE -> stays IDLE; start during SWEEP with new f_start -> ignored, sequence unchanged.
